// File: rtl/q_8_10_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// q_8_10_pkg : state width and state encoding for the q_8_10 FSM
// Rev 1.0
// ---------------------------------------------------------------------------
package q_8_10_pkg;

  localparam int st_width = 2;

  typedef enum logic [st_width-1:0] {
    S_0 = 2'b00,
    S_1 = 2'b01,
    S_2 = 2'b10,
    S_3 = 2'b11
  } state_t;

endpackage : q_8_10_pkg
`default_nettype wire

// File: rtl/q_8_10.sv
`default_nettype none
// ---------------------------------------------------------------------------
// q_8_10 : four-state FSM steered by serial inputs x/y; present state is the output
// Rev 1.0
// ---------------------------------------------------------------------------
module q_8_10
  import q_8_10_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                x,
  input  logic                y,
  output logic [st_width-1:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_0;
    case (state_q)
      S_0: state_d = x ? S_1 : S_0;
      S_1: state_d = y ? S_3 : S_2;
      S_2: begin
        if (!x)     state_d = S_0;
        else if (y) state_d = S_3;
        else        state_d = S_2;
      end
      S_3: begin
        if (x)      state_d = S_0;
        else if (y) state_d = S_3;
        else        state_d = S_2;
      end
      // Anything not a legal encoding (e.g. X before reset) recovers to S_0
      default: state_d = S_0;
    endcase
  end

  assign state = state_q;

endmodule : q_8_10
`default_nettype wire

// File: tb/tb_q_8_10.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_q_8_10 : directed stimulus with an expected-state scoreboard for q_8_10
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_q_8_10;

  logic       clk;
  logic       rst_b;
  logic       x;
  logic       y;
  logic [1:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [1:0] sb[$];
  logic [1:0] cur;

  q_8_10 dut (
    .clk   (clk),
    .rst_b (rst_b),
    .x     (x),
    .y     (y),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Transition table written straight from the state diagram
  function automatic logic [1:0] model(input logic [1:0] s, input logic xi, input logic yi);
    logic [1:0] n;
    n = 2'b00;
    unique case ({s, xi, yi})
      4'b00_00: n = 2'b00;  4'b00_01: n = 2'b00;
      4'b00_10: n = 2'b01;  4'b00_11: n = 2'b01;
      4'b01_00: n = 2'b10;  4'b01_01: n = 2'b11;
      4'b01_10: n = 2'b10;  4'b01_11: n = 2'b11;
      4'b10_00: n = 2'b00;  4'b10_01: n = 2'b00;
      4'b10_10: n = 2'b10;  4'b10_11: n = 2'b11;
      4'b11_00: n = 2'b10;  4'b11_01: n = 2'b11;
      4'b11_10: n = 2'b00;  4'b11_11: n = 2'b00;
      default:  n = 2'b00;
    endcase
    return n;
  endfunction

  task automatic step(input logic rb, input logic xi, input logic yi, input string tag);
    logic [1:0] exp;
    @(negedge clk);
    rst_b = rb;
    x     = xi;
    y     = yi;
    exp   = rb ? model(cur, xi, yi) : 2'b00;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    n_checks++;
    assert (state === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, state, exp);
    end
    cur = exp;
  endtask

  initial begin
    rst_b = 1'b0;
    x     = 1'b0;
    y     = 1'b0;
    cur   = 2'b00;

    // Reset and idle
    step(1'b0, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 1'b0, "idle_hold");

    // S_0 -> S_1 -> S_2 -> S_0
    step(1'b1, 1'b1, 1'b0, "p1_s0_s1");
    step(1'b1, 1'b0, 1'b0, "p1_s1_s2");
    step(1'b1, 1'b0, 1'b0, "p1_s2_s0");

    // S_2 hold and exit through S_3
    step(1'b1, 1'b1, 1'b0, "p2_s0_s1");
    step(1'b1, 1'b1, 1'b0, "p2_s1_s2");
    step(1'b1, 1'b1, 1'b0, "p2_s2_hold");
    step(1'b1, 1'b1, 1'b1, "p2_s2_s3");
    step(1'b1, 1'b1, 1'b1, "p2_s3_s0");

    // S_1 with y=1, S_3 hold and exit to S_2
    step(1'b1, 1'b1, 1'b1, "p3_s0_s1");
    step(1'b1, 1'b0, 1'b1, "p3_s1_s3");
    step(1'b1, 1'b0, 1'b1, "p3_s3_hold");
    step(1'b1, 1'b0, 1'b0, "p3_s3_s2");

    // Reset mid-sequence while in S_2, with inputs that would otherwise move it
    step(1'b0, 1'b1, 1'b1, "mid_reset");
    step(1'b1, 1'b0, 1'b0, "post_reset_hold");

    // Every (state, x, y) combination
    for (int s = 0; s < 4; s++) begin
      for (int v = 0; v < 4; v++) begin
        step(1'b0, 1'b1, 1'b1, "ex_reset");
        if (s != 0) step(1'b1, 1'b1, 1'b0, "ex_to_s1");
        if (s == 2) step(1'b1, 1'b0, 1'b0, "ex_to_s2");
        if (s == 3) step(1'b1, 1'b0, 1'b1, "ex_to_s3");
        step(1'b1, v[1], v[0], $sformatf("ex_s%0d_xy%0d", s, v));
      end
    end

    // Reset held across several edges with varied inputs
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i[1], i[0], "held_reset");
    end

    // Random walk against the model
    for (int i = 0; i < 64; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_q_8_10
`default_nettype wire
